apb_slave_fabric7: RTL

//  Parametrised APB fan-out fabric between the ahb2apb7 bridge and up to 16 APB peripherals (ALUT7, MACs, ...).

---
 rtl/apb_slave_fabric7.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/apb_slave_fabric7.sv
// rtl/apb_slave_fabric7.sv - APB fan-out fabric decoding one upstream transfer onto NUM_SLV windows.
// Optional access timeout is enabled by defining APB_FABRIC_TMO_EN.
module apb_slave_fabric7 #(
    parameter int          NUM_SLV    = 5,
    parameter logic [31:0] BASE_ADDR  = 32'h00A00000,
    parameter int          WIN_BITS   = 16,
    parameter int          TMO_CYCLES = 255
) (
    input  logic                     pclk7,
    input  logic                     n_preset7,
    input  logic                     s_psel,
    input  logic                     s_penable,
    input  logic                     s_pwrite,
    input  logic [31:0]              s_paddr,
    input  logic [31:0]              s_pwdata,
    output logic [31:0]              s_prdata,
    output logic                     s_pready,
    output logic                     s_pslverr,
    output logic [NUM_SLV-1:0]       m_psel,
    output logic                     m_penable,
    output logic                     m_pwrite,
    output logic [31:0]              m_paddr,
    output logic [31:0]              m_pwdata,
    input  logic [32*NUM_SLV-1:0]    m_prdata,
    input  logic [NUM_SLV-1:0]       m_pready,
    input  logic [NUM_SLV-1:0]       m_pslverr,
    output logic                     tmo_evt
);

    localparam int OW = 32 - WIN_BITS;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t               state_q, state_d;
    logic [NUM_SLV-1:0]   m_psel_q, m_psel_d;
    logic                 m_penable_q, m_penable_d;
    logic                 m_pwrite_q, m_pwrite_d;
    logic [31:0]          m_paddr_q, m_paddr_d;
    logic [31:0]          m_pwdata_q, m_pwdata_d;
    logic [31:0]          s_prdata_q, s_prdata_d;
    logic                 s_pready_q, s_pready_d;
    logic                 s_pslverr_q, s_pslverr_d;

    logic [OW-1:0]        off;
    logic [NUM_SLV-1:0]   dec_sel;
    logic                 hit;
    logic [31:0]          sel_rdata;
    logic                 sel_rdy;
    logic                 sel_err;

    assign off = s_paddr[31:WIN_BITS] - BASE_ADDR[31:WIN_BITS];

    // Window decode doubles as the one-hot select; a miss leaves it all zero.
    always_comb begin
        dec_sel = '0;
        for (int k = 0; k < NUM_SLV; k++) begin
            if (s_paddr >= BASE_ADDR && off == OW'(k)) begin
                dec_sel[k] = 1'b1;
            end
        end
    end

    assign hit = |dec_sel;

    // The registered select steers the response mux, so no separate index is kept.
    always_comb begin
        sel_rdata = '0;
        sel_rdy   = 1'b0;
        sel_err   = 1'b0;
        for (int k = 0; k < NUM_SLV; k++) begin
            if (m_psel_q[k]) begin
                sel_rdata = sel_rdata | m_prdata[32*k +: 32];
                sel_rdy   = sel_rdy | m_pready[k];
                sel_err   = sel_err | m_pslverr[k];
            end
        end
    end

`ifdef APB_FABRIC_TMO_EN
    localparam logic [15:0] TMO_LAST = 16'(TMO_CYCLES - 1);
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        tmo_evt_q, tmo_evt_d;

    always_ff @(posedge pclk7) begin
        if (!n_preset7) begin
            tmo_cnt_q <= '0;
            tmo_evt_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_evt_q <= tmo_evt_d;
        end
    end

    assign tmo_evt = tmo_evt_q;
`else
    assign tmo_evt = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        m_psel_d    = m_psel_q;
        m_penable_d = m_penable_q;
        m_pwrite_d  = m_pwrite_q;
        m_paddr_d   = m_paddr_q;
        m_pwdata_d  = m_pwdata_q;
        s_prdata_d  = '0;
        s_pready_d  = 1'b0;
        s_pslverr_d = 1'b0;
`ifdef APB_FABRIC_TMO_EN
        tmo_cnt_d   = tmo_cnt_q;
        tmo_evt_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (s_psel && !s_penable) begin
                    if (hit) begin
                        state_d    = SETUP;
                        m_psel_d   = dec_sel;
                        m_pwrite_d = s_pwrite;
                        m_paddr_d  = s_paddr;
                        m_pwdata_d = s_pwdata;
                    end else begin
                        state_d     = DONE;
                        s_pready_d  = 1'b1;
                        s_pslverr_d = 1'b1;
                    end
                end
            end
            SETUP: begin
                state_d     = ACCESS;
                m_penable_d = 1'b1;
`ifdef APB_FABRIC_TMO_EN
                tmo_cnt_d   = '0;
`endif
            end
            ACCESS: begin
`ifdef APB_FABRIC_TMO_EN
                tmo_cnt_d = tmo_cnt_q + 16'd1;
`endif
                if (sel_rdy) begin
                    state_d     = DONE;
                    s_pready_d  = 1'b1;
                    s_prdata_d  = m_pwrite_q ? 32'h0 : sel_rdata;
                    s_pslverr_d = sel_err;
                    m_psel_d    = '0;
                    m_penable_d = 1'b0;
                end
`ifdef APB_FABRIC_TMO_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    state_d     = DONE;
                    s_pready_d  = 1'b1;
                    s_pslverr_d = 1'b1;
                    m_psel_d    = '0;
                    m_penable_d = 1'b0;
                    tmo_evt_d   = 1'b1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk7) begin
        if (!n_preset7) begin
            state_q     <= IDLE;
            m_psel_q    <= '0;
            m_penable_q <= 1'b0;
            m_pwrite_q  <= 1'b0;
            m_paddr_q   <= '0;
            m_pwdata_q  <= '0;
            s_prdata_q  <= '0;
            s_pready_q  <= 1'b0;
            s_pslverr_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            m_psel_q    <= m_psel_d;
            m_penable_q <= m_penable_d;
            m_pwrite_q  <= m_pwrite_d;
            m_paddr_q   <= m_paddr_d;
            m_pwdata_q  <= m_pwdata_d;
            s_prdata_q  <= s_prdata_d;
            s_pready_q  <= s_pready_d;
            s_pslverr_q <= s_pslverr_d;
        end
    end

    assign m_psel    = m_psel_q;
    assign m_penable = m_penable_q;
    assign m_pwrite  = m_pwrite_q;
    assign m_paddr   = m_paddr_q;
    assign m_pwdata  = m_pwdata_q;
    assign s_prdata  = s_prdata_q;
    assign s_pready  = s_pready_q;
    assign s_pslverr = s_pslverr_q;

endmodule
